// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-port arbiter in front of a single data memory. Port 0 is the CPU memory
// stage and port 1 is a loader/debug port. One transaction is in flight at a
// time: a request is granted from IDLE, the memory is driven for LAT cycles in
// BUSY, and the requester is acknowledged for one cycle in DONE.
//
// Parameters
//   LAT   memory access cycles per transaction, legal range 1..15
//   RR    1 = round-robin between the ports, 0 = fixed priority to port 0
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   p0_req/wen/addr/wdata           CPU request (wen 1 = store, 0 = load)
//   p1_req/wen/addr/wdata           loader/debug request, same meanings
//   p0_gnt, p1_gnt                  one-cycle pulse: request accepted, latched
//   p0_ack, p1_ack                  one-cycle pulse: transaction complete
//   rdata                           load data, held until the next load ends
//   p0_stall                        p0_req and not p0_ack (CPU pipeline freeze)
//   dmem_en, dmem_wen               memory enable / write enable (BUSY only)
//   dmem_addr, dmem_wdata           latched address / write data
//   dmem_rdata                      memory read data, valid in last BUSY cycle
// -----------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int LAT = 2,
   parameter int RR  = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic        p0_wen,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   input  logic        p1_req,
   input  logic        p1_wen,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p0_gnt,
   output logic        p1_gnt,
   output logic        p0_ack,
   output logic        p1_ack,
   output logic [31:0] rdata,
   output logic        p0_stall,
   output logic        dmem_en,
   output logic        dmem_wen,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata
);

   localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        last_id;     // port granted most recently
   logic        lat_id;      // port owning the current transaction
   logic        lat_wen;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] rdata_q;
   logic        any_req;
   logic        win_id;

   // Winner selection. With a single requester it simply wins; on contention
   // round-robin favours the port that was not granted last.
   always_comb begin
      any_req = p0_req | p1_req;
      win_id  = 1'b0;
      if (p0_req && p1_req) begin
         win_id = (RR != 0) ? ~last_id : 1'b0;
      end else if (p1_req) begin
         win_id = 1'b1;
      end
   end

   // State register. The memory strobes decode from this, so an asynchronous
   // reset drops dmem_en immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and control outputs; grant is a Mealy output of IDLE so that
   // the request is accepted on the same edge that enters BUSY.
   always_comb begin
      state_nxt = state;
      p0_gnt    = 1'b0;
      p1_gnt    = 1'b0;
      p0_ack    = 1'b0;
      p1_ack    = 1'b0;
      dmem_en   = 1'b0;
      dmem_wen  = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               p0_gnt    = ~win_id;
               p1_gnt    = win_id;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            dmem_en  = 1'b1;
            dmem_wen = lat_wen;
            if (cnt == 4'd0) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            p0_ack    = ~lat_id;
            p1_ack    = lat_id;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Transaction latch, access counter, round-robin pointer and load data.
   // The pointer resets to port 1 so port 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= 4'd0;
         last_id   <= 1'b1;
         lat_id    <= 1'b0;
         lat_wen   <= 1'b0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         rdata_q   <= 32'd0;
      end else if (state == IDLE && any_req) begin
         cnt       <= LAT_M1;
         last_id   <= win_id;
         lat_id    <= win_id;
         lat_wen   <= win_id ? p1_wen   : p0_wen;
         lat_addr  <= win_id ? p1_addr  : p0_addr;
         lat_wdata <= win_id ? p1_wdata : p0_wdata;
      end else if (state == BUSY) begin
         if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end else if (!lat_wen) begin
            rdata_q <= dmem_rdata;
         end
      end
   end

   assign dmem_addr  = lat_addr;
   assign dmem_wdata = lat_wdata;
   assign rdata      = rdata_q;
   assign p0_stall   = p0_req & ~p0_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic        p0_req, p0_wen, p1_req, p1_wen;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

   logic        p0_gnt, p1_gnt, p0_ack, p1_ack, p0_stall, dmem_en, dmem_wen;
   logic [31:0] rdata, dmem_addr, dmem_wdata, dmem_rdata;

   logic        fp_p0_gnt, fp_p1_gnt, fp_p0_ack, fp_p1_ack, fp_p0_stall;
   logic        fp_dmem_en, fp_dmem_wen;
   logic [31:0] fp_rdata, fp_dmem_addr, fp_dmem_wdata, fp_dmem_rdata;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mem [0:15];

   dmem_arbiter #(.LAT(2), .RR(1)) u_rr (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_ack(p0_ack), .p1_ack(p1_ack),
      .rdata(rdata), .p0_stall(p0_stall),
      .dmem_en(dmem_en), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
   );

   dmem_arbiter #(.LAT(2), .RR(0)) u_fp (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p0_gnt(fp_p0_gnt), .p1_gnt(fp_p1_gnt), .p0_ack(fp_p0_ack), .p1_ack(fp_p1_ack),
      .rdata(fp_rdata), .p0_stall(fp_p0_stall),
      .dmem_en(fp_dmem_en), .dmem_wen(fp_dmem_wen), .dmem_addr(fp_dmem_addr),
      .dmem_wdata(fp_dmem_wdata), .dmem_rdata(fp_dmem_rdata)
   );

   assign fp_dmem_rdata = 32'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory for the round-robin instance; contents preloaded while in reset.
   assign dmem_rdata = mem[dmem_addr[5:2]];
   always @(posedge clk) begin
      if (!rst_n) begin
         mem[4] <= 32'hDEADBEEF;   // 0x10
         mem[5] <= 32'h12345678;   // 0x14
      end else if (dmem_en && dmem_wen) begin
         mem[dmem_addr[5:2]] <= dmem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      p0_req = 1'b0; p0_wen = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
      p1_req = 1'b0; p1_wen = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;

      // Reset state
      repeat (2) @(posedge clk);
      #2;
      chk("rst_p0_gnt", 32'(p0_gnt), 32'h0);
      chk("rst_p1_gnt", 32'(p1_gnt), 32'h0);
      chk("rst_p0_ack", 32'(p0_ack), 32'h0);
      chk("rst_p1_ack", 32'(p1_ack), 32'h0);
      chk("rst_dmem_en", 32'(dmem_en), 32'h0);
      chk("rst_dmem_wen", 32'(dmem_wen), 32'h0);
      chk("rst_dmem_addr", dmem_addr, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      #1 rst_n = 1'b1;

      // p0 load from 0x10: gnt at T, BUSY T+1..T+2, ack at T+3
      tick(); p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h10; #1;
      chk("ld_gnt_T", 32'(p0_gnt), 32'h1);
      chk("ld_p1_gnt_T", 32'(p1_gnt), 32'h0);
      chk("ld_en_T", 32'(dmem_en), 32'h0);
      tick(); p0_req = 1'b0; p0_addr = 32'h3C; #1;
      chk("ld_en_T1", 32'(dmem_en), 32'h1);
      chk("ld_addr_T1", dmem_addr, 32'h10);
      chk("ld_wen_T1", 32'(dmem_wen), 32'h0);
      chk("ld_gnt_T1", 32'(p0_gnt), 32'h0);
      tick(); #1;
      chk("ld_en_T2", 32'(dmem_en), 32'h1);
      chk("ld_addr_T2", dmem_addr, 32'h10);
      chk("ld_ack_T2", 32'(p0_ack), 32'h0);
      tick(); #1;
      chk("ld_ack_T3", 32'(p0_ack), 32'h1);
      chk("ld_rdata_T3", rdata, 32'hDEADBEEF);
      chk("ld_en_T3", 32'(dmem_en), 32'h0);
      chk("ld_addr_hold_T3", dmem_addr, 32'h10);
      tick(); #1;
      chk("ld_ack_T4", 32'(p0_ack), 32'h0);
      chk("ld_rdata_hold", rdata, 32'hDEADBEEF);

      // Reset pulse between cycles so the pointer favours port 0 again
      tick(); rst_n = 1'b0; #2; rst_n = 1'b1;

      // Both ports requesting continuously: RR alternates p0,p1 every 4 cycles;
      // fixed priority grants only p0
      for (int c = 0; c < 16; c++) begin
         tick();
         p0_req = (c < 13); p0_wen = 1'b0; p0_addr = 32'h10;
         p1_req = (c < 13); p1_wen = 1'b0; p1_addr = 32'h14;
         #1;
         chk($sformatf("rr_p0_gnt_c%0d", c), 32'(p0_gnt), 32'((c % 8) == 0));
         chk($sformatf("rr_p1_gnt_c%0d", c), 32'(p1_gnt), 32'((c % 8) == 4));
         chk($sformatf("fp_p0_gnt_c%0d", c), 32'(fp_p0_gnt), 32'((c % 4) == 0));
         chk($sformatf("fp_p1_gnt_c%0d", c), 32'(fp_p1_gnt), 32'h0);
         if ((c % 4) == 3) begin
            chk($sformatf("rr_p0_ack_c%0d", c), 32'(p0_ack), 32'((c % 8) == 3));
            chk($sformatf("rr_p1_ack_c%0d", c), 32'(p1_ack), 32'((c % 8) == 7));
            chk($sformatf("rr_rdata_c%0d", c), rdata,
                ((c % 8) == 3) ? 32'hDEADBEEF : 32'h12345678);
         end
      end

      // p1 store 0x55 to 0x20, then p0 load from 0x20
      tick(); p1_req = 1'b1; p1_wen = 1'b1; p1_addr = 32'h20; p1_wdata = 32'h55; #1;
      chk("st_p1_gnt", 32'(p1_gnt), 32'h1);
      chk("st_p0_gnt", 32'(p0_gnt), 32'h0);
      tick(); p1_req = 1'b0; p1_wdata = 32'hAA; #1;
      chk("st_en", 32'(dmem_en), 32'h1);
      chk("st_wen", 32'(dmem_wen), 32'h1);
      chk("st_addr", dmem_addr, 32'h20);
      chk("st_wdata", dmem_wdata, 32'h55);
      tick(); #1;
      chk("st_wdata_2", dmem_wdata, 32'h55);
      tick(); #1;
      chk("st_p1_ack", 32'(p1_ack), 32'h1);
      chk("st_rdata_kept", rdata, 32'h12345678);
      chk("st_wen_off", 32'(dmem_wen), 32'h0);
      tick(); p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h20; #1;
      chk("ld20_gnt", 32'(p0_gnt), 32'h1);
      tick(); p0_req = 1'b0; #1;
      tick(); #1;
      tick(); #1;
      chk("ld20_ack", 32'(p0_ack), 32'h1);
      chk("ld20_rdata", rdata, 32'h55);

      // Reset in the middle of BUSY aborts the load
      tick(); p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h10; #1;
      chk("ab_gnt", 32'(p0_gnt), 32'h1);
      tick(); p0_req = 1'b0; #1;
      chk("ab_en_busy", 32'(dmem_en), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("ab_en_async", 32'(dmem_en), 32'h0);
      chk("ab_addr_clr", dmem_addr, 32'h0);
      chk("ab_rdata_clr", rdata, 32'h0);
      #2 rst_n = 1'b1;
      p1_req = 1'b1; p1_wen = 1'b0; p1_addr = 32'h10;
      #1;
      chk("ab_p1_gnt", 32'(p1_gnt), 32'h1);
      tick(); p1_req = 1'b0; #1;
      chk("ab_p0_ack_1", 32'(p0_ack), 32'h0);
      chk("ab_en_new", 32'(dmem_en), 32'h1);
      chk("ab_addr_new", dmem_addr, 32'h10);
      tick(); #1;
      chk("ab_p0_ack_2", 32'(p0_ack), 32'h0);
      tick(); #1;
      chk("ab_p0_ack_3", 32'(p0_ack), 32'h0);
      chk("ab_p1_ack", 32'(p1_ack), 32'h1);
      chk("ab_rdata", rdata, 32'hDEADBEEF);

      // p0 held with no competition: stall from grant cycle, low in ack cycle
      tick(); p0_req = 1'b1; p0_wen = 1'b0; p0_addr = 32'h14;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) tick();
         #1;
         chk($sformatf("stall_c%0d", c), 32'(p0_stall), 32'(c < 3));
         chk($sformatf("stall_ack_c%0d", c), 32'(p0_ack), 32'(c == 3));
      end
      chk("stall_rdata", rdata, 32'h12345678);
      tick(); p0_req = 1'b0; #1;
      chk("stall_idle", 32'(p0_stall), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
